// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit order, the 16 hex glyphs
// and the capture FSM encoding, used by both the encoder and the decoder.
package seg7_pkg;

  // Segment order on the 7-bit bus: a is bit 6, g is bit 0, active-high.
  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
  } seg_bits_t;

  // Entry i is the glyph for hex digit i.
  localparam logic [15:0][6:0] SEG_PATTERNS = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  typedef enum logic {
    SETTLE = 1'b0,
    HELD   = 1'b1
  } state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_PATTERNS[nibble];
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational glyph-to-nibble decoder; unknown patterns give 0 with err set.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    nibble = 4'h0;
    err    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_PATTERNS[i]) begin
        nibble = 4'(i);
        err    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Recovers the hex value shown on a multiplexed 4-digit 7-segment display by
// sampling an/seg, waiting for each digit to settle and assembling frames.
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        value_changed,
  output logic        stale
);

  localparam logic [7:0]  STABLE_MAX  = 8'(STABLE_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_MAX = 20'(TIMEOUT_CYCLES - 1);

  logic [6:0]  seg_meta, seg_sync, seg_prev;
  logic [3:0]  an_meta, an_sync, an_prev;
  logic [7:0]  stable_cnt, stable_cnt_next;
  logic [19:0] tmo_cnt;
  state_t      state, state_next;
  logic [3:0]  seen, seen_next;
  logic [3:0]  nib_buf [4];
  logic [15:0] buf_flat;
  logic [3:0]  err_buf;
  logic [3:0]  dec_nibble;
  logic        dec_err;
  logic        sample_changed, capture, one_hot, valid_capture, frame_done, tmo_hit;

  seg7_pattern_decode u_decode (
    .seg    (seg_sync),
    .nibble (dec_nibble),
    .err    (dec_err)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_flat
      assign buf_flat[gi*4 +: 4] = nib_buf[gi];
    end
  endgenerate

  always_comb begin
    sample_changed  = {an_sync, seg_sync} != {an_prev, seg_prev};
    stable_cnt_next = stable_cnt;
    if (sample_changed)
      stable_cnt_next = 8'd0;
    else if (stable_cnt != STABLE_MAX)
      stable_cnt_next = stable_cnt + 8'd1;

    state_next = state;
    capture    = 1'b0;
    case (state)
      SETTLE: if (stable_cnt_next == STABLE_MAX) begin
        capture    = 1'b1;
        state_next = HELD;
      end
      HELD: if (sample_changed) state_next = SETTLE;
      default: state_next = SETTLE;
    endcase

    one_hot       = (an_sync != 4'd0) && ((an_sync & (an_sync - 4'd1)) == 4'd0);
    valid_capture = capture && one_hot;
    frame_done    = (seen == 4'hF);
    // A valid capture clears the timeout counter, so it always beats expiry.
    tmo_hit       = !valid_capture && (tmo_cnt == TIMEOUT_MAX);

    seen_next = seen;
    if (frame_done || tmo_hit) seen_next = 4'd0;
    if (valid_capture)         seen_next = seen_next | an_sync;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_meta      <= '0;
      seg_sync      <= '0;
      seg_prev      <= '0;
      an_meta       <= '0;
      an_sync       <= '0;
      an_prev       <= '0;
      stable_cnt    <= '0;
      tmo_cnt       <= '0;
      state         <= SETTLE;
      seen          <= '0;
      err_buf       <= '0;
      for (int i = 0; i < 4; i++) nib_buf[i] <= '0;
      value         <= '0;
      digit_err     <= '0;
      frame_valid   <= 1'b0;
      value_changed <= 1'b0;
      stale         <= 1'b0;
    end else begin
      seg_meta   <= seg;
      seg_sync   <= seg_meta;
      seg_prev   <= seg_sync;
      an_meta    <= an;
      an_sync    <= an_meta;
      an_prev    <= an_sync;
      stable_cnt <= stable_cnt_next;
      state      <= state_next;
      seen       <= seen_next;

      if (valid_capture || tmo_hit) tmo_cnt <= '0;
      else                          tmo_cnt <= tmo_cnt + 20'd1;

      for (int i = 0; i < 4; i++) begin
        if (valid_capture && an_sync[i]) begin
          nib_buf[i] <= dec_nibble;
          err_buf[i] <= dec_err;
        end
      end

      frame_valid   <= frame_done;
      value_changed <= frame_done && (buf_flat != value);
      if (frame_done) begin
        value     <= buf_flat;
        digit_err <= err_buf;
        stale     <= 1'b0;
      end else if (tmo_hit) begin
        stale <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Self-checking bench: table of display frames plus hand-written glitch,
// enable-error, timeout and reset sequences, with a frame scoreboard.
module tb_seg7_capture_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_in = 7'h00;
  logic [3:0]  an_in = 4'h0;

  logic [15:0] value_a, value_b;
  logic [3:0]  digit_err_a, digit_err_b;
  logic        frame_valid_a, frame_valid_b;
  logic        value_changed_a, value_changed_b;
  logic        stale_a, stale_b;

  always #5 clk = ~clk;

  seg7_capture_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(65535)) dut_a (
    .clk           (clk),
    .rst           (rst),
    .seg           (seg_in),
    .an            (an_in),
    .value         (value_a),
    .digit_err     (digit_err_a),
    .frame_valid   (frame_valid_a),
    .value_changed (value_changed_a),
    .stale         (stale_a)
  );

  seg7_capture_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut_b (
    .clk           (clk),
    .rst           (rst),
    .seg           (seg_in),
    .an            (an_in),
    .value         (value_b),
    .digit_err     (digit_err_b),
    .frame_valid   (frame_valid_b),
    .value_changed (value_changed_b),
    .stale         (stale_b)
  );

  typedef struct {
    logic [27:0] segs;     // {digit3, digit2, digit1, digit0}
    logic [15:0] value;
    logic [3:0]  err;
    logic        changed;
  } vec_t;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  err;
    logic        changed;
  } frame_t;

  vec_t        tbl [7];
  frame_t      sb [$];
  frame_t      got;
  int          checks = 0;
  int          errors = 0;
  int          fv_b_cnt = 0;
  int          fvb0;
  logic [15:0] model_prev = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an_in  = a;
    seg_in = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [27:0] segs);
    for (int d = 3; d >= 0; d--) hold(4'(1 << d), segs[d*7 +: 7], 10);
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] e);
    frame_t f;
    f.value   = v;
    f.err     = e;
    f.changed = (v != model_prev);
    model_prev = v;
    sb.push_back(f);
  endtask

  task automatic wait_empty(input string name);
    for (int n = 0; n < 60 && sb.size() != 0; n++) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s missing_frames actual=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (frame_valid_b) fv_b_cnt++;
    if (frame_valid_a) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame actual=%h required=no_frame", value_a);
      end else begin
        got = sb.pop_front();
        $display("frame value=%h digit_err=%b value_changed=%b", value_a, digit_err_a, value_changed_a);
        check("frame_value", 32'(value_a), 32'(got.value));
        check("frame_digit_err", 32'(digit_err_a), 32'(got.err));
        check("frame_value_changed", 32'(value_changed_a), 32'(got.changed));
      end
    end
  end

  initial begin
    tbl[0] = '{segs:{7'h30, 7'h6D, 7'h79, 7'h33}, value:16'h1234, err:4'b0000, changed:1'b1};
    tbl[1] = '{segs:{7'h30, 7'h6D, 7'h79, 7'h33}, value:16'h1234, err:4'b0000, changed:1'b0};
    tbl[2] = '{segs:{7'h30, 7'h6D, 7'h00, 7'h33}, value:16'h1204, err:4'b0010, changed:1'b1};
    tbl[3] = '{segs:{7'h77, 7'h1F, 7'h4E, 7'h3D}, value:16'hABCD, err:4'b0000, changed:1'b1};
    tbl[4] = '{segs:{7'h7E, 7'h7E, 7'h7E, 7'h7E}, value:16'h0000, err:4'b0000, changed:1'b1};
    tbl[5] = '{segs:{7'h7F, 7'h7B, 7'h5F, 7'h70}, value:16'h8967, err:4'b0000, changed:1'b1};
    tbl[6] = '{segs:{7'h5B, 7'h33, 7'h30, 7'h7E}, value:16'h5410, err:4'b0000, changed:1'b1};

    repeat (3) @(negedge clk);
    check("reset_value", 32'(value_a), 32'h0);
    check("reset_digit_err", 32'(digit_err_a), 32'h0);
    check("reset_frame_valid", 32'(frame_valid_a), 32'h0);
    check("reset_value_changed", 32'(value_changed_a), 32'h0);
    check("reset_stale", 32'(stale_a), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Table-driven frames; value_changed expectations are stated explicitly.
    for (int i = 0; i < 7; i++) begin
      frame_t f;
      f.value   = tbl[i].value;
      f.err     = tbl[i].err;
      f.changed = tbl[i].changed;
      sb.push_back(f);
      model_prev = tbl[i].value;
      scan(tbl[i].segs);
      wait_empty("table_frame");
    end

    // Invalid digit enables: no capture anywhere; short-timeout unit goes stale.
    check("pre_timeout_stale_b", 32'(stale_b), 32'h0);
    fvb0 = fv_b_cnt;
    hold(4'b0000, 7'h30, 20);
    hold(4'b0011, 7'h30, 20);
    check("timeout_stale_b", 32'(stale_b), 32'h1);
    check("timeout_value_b", 32'(value_b), 32'h5410);
    check("timeout_no_frame_b", 32'(fv_b_cnt - fvb0), 32'h0);
    check("no_timeout_stale_a", 32'(stale_a), 32'h0);
    check("retained_value_a", 32'(value_a), 32'h5410);

    // Glitching digit 0 must not capture; the frame completes only on the clean glyph.
    push_frame(16'h1230, 4'b0000);
    hold(4'b1000, 7'h30, 10);
    hold(4'b0100, 7'h6D, 10);
    hold(4'b0010, 7'h79, 10);
    for (int k = 0; k < 10; k++) hold(4'b0001, (k % 2 == 1) ? 7'h6D : 7'h30, 2);
    hold(4'b0001, 7'h7E, 10);
    wait_empty("glitch_frame");

    // Reset mid-frame discards three captured digits.
    hold(4'b0100, 7'h30, 10);
    hold(4'b0010, 7'h30, 10);
    hold(4'b0001, 7'h30, 10);
    hold(4'b0000, 7'h00, 5);
    rst = 1'b1;
    #1;
    check("async_reset_value", 32'(value_a), 32'h0);
    check("async_reset_stale", 32'(stale_a), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_prev = 16'h0000;
    hold(4'b0000, 7'h00, 10);
    push_frame(16'hFEDC, 4'b0000);
    scan({7'h47, 7'h4F, 7'h3D, 7'h4E});
    wait_empty("post_reset_frame");
    hold(4'b0000, 7'h00, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
